// File: rtl/vrf_wb_arbiter_pkg.sv
// Shared constants and types for the vector register file writeback path.
package vrf_pkg;

  localparam int DATA_W  = 256;
  localparam int ADDR_W  = 5;
  localparam int VREG_LO = 16;
  localparam int VREG_HI = 23;

  // Read-only performance counter addresses that sit just above the vector bank
  localparam logic [ADDR_W-1:0] PERF_STALL = 5'd24;
  localparam logic [ADDR_W-1:0] PERF_CPI   = 5'd25;
  localparam logic [ADDR_W-1:0] PERF_ARITH = 5'd26;
  localparam logic [ADDR_W-1:0] PERF_MEM   = 5'd27;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } vrf_wr_t;

  // True when addr lies inside the writable window [lo, hi]
  function automatic logic addr_writable(input int unsigned addr,
                                         input int unsigned lo,
                                         input int unsigned hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/vrf_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: rotate-priority one-hot grant plus the rotation pointer.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            cand;

  // Search from the pointer upward (wrapping) and grant the first requester found
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    if (en && !rst) begin
      for (int k = 0; k < N; k++) begin
        cand = (int'(ptr_q) + k) % N;
        if (!found && req[cand]) begin
          gnt[cand] = 1'b1;
          gnt_idx   = IW'(cand);
          found     = 1'b1;
        end
      end
    end
  end

  // Next pointer: one past the winner, wrapping at N; unchanged without a grant
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) begin
      ptr_d = (int'(gnt_idx) == N - 1) ? '0 : IW'(int'(gnt_idx) + 1);
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Arbitrates N_REQ writeback requesters onto the single regfile write port,
// registers the chosen write, screens out-of-bank addresses and counts conflicts.
module vrf_wb_arbiter import vrf_pkg::*; #(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = vrf_pkg::DATA_W,
  parameter int ADDR_W  = vrf_pkg::ADDR_W,
  parameter int VREG_LO = vrf_pkg::VREG_LO,
  parameter int VREG_HI = vrf_pkg::VREG_HI
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      wb_stall,
  input  logic                      cnt_clr,
  output logic                      vwe3,
  output logic [ADDR_W-1:0]         vwa3,
  output logic [DATA_W-1:0]         vwd3,
  output logic                      bad_addr_err,
  output logic [2:0]                err_req_id,
  output logic [31:0]               conflict_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic [N_REQ-1:0]  gnt;
  logic [IW-1:0]     gnt_idx;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              in_range;
  logic              conflict_evt;

  wr_t         wr_q, wr_d;
  logic        err_q, err_d;
  logic [2:0]  err_id_q, err_id_d;
  logic [31:0] conflict_q, conflict_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (!wb_stall),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign in_range  = addr_writable(32'(sel_addr), VREG_LO, VREG_HI);

  // A denied valid requester: two or more competing, or any waiting through a stall
  assign conflict_evt = wb_stall ? (|req_valid) : ($countones(req_valid) >= 2);

  // Write-port next state: out-of-bank transfers complete but never enable the write
  always_comb begin
    wr_d    = wr_q;
    wr_d.we = 1'b0;
    if (xfer) begin
      wr_d.we   = in_range;
      wr_d.addr = sel_addr;
      wr_d.data = sel_data;
    end
  end

  // Sticky error flag; the requester id is latched only for the first offence
  always_comb begin
    err_d    = err_q;
    err_id_d = err_id_q;
    if (xfer && !in_range) begin
      err_d = 1'b1;
      if (!err_q) err_id_d = 3'(gnt_idx);
    end
  end

  // Saturating conflict counter with clear taking priority over increment
  always_comb begin
    conflict_d = conflict_q;
    if (cnt_clr)           conflict_d = '0;
    else if (conflict_evt) conflict_d = sat_inc(conflict_q);
  end

  // State registers; reset drops any in-flight write
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= '0;
      err_q      <= 1'b0;
      err_id_q   <= '0;
      conflict_q <= '0;
    end else begin
      wr_q       <= wr_d;
      err_q      <= err_d;
      err_id_q   <= err_id_d;
      conflict_q <= conflict_d;
    end
  end

  assign vwe3           = wr_q.we;
  assign vwa3           = wr_q.addr;
  assign vwd3           = wr_q.data;
  assign bad_addr_err   = err_q;
  assign err_req_id     = err_id_q;
  assign conflict_count = conflict_q;

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Scoreboard bench for vrf_wb_arbiter: directed stimulus pushes expected grants
// and writes; a negedge monitor pops and compares them as the DUT presents them.
module tb_vrf_wb_arbiter;

  localparam int N  = 2;
  localparam int DW = 256;
  localparam int AW = 5;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wb_stall;
  logic            cnt_clr;
  logic            vwe3;
  logic [AW-1:0]   vwa3;
  logic [DW-1:0]   vwd3;
  logic            bad_addr_err;
  logic [2:0]      err_req_id;
  logic [31:0]     conflict_count;

  vrf_wb_arbiter #(.N_REQ(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .wb_stall       (wb_stall),
    .cnt_clr        (cnt_clr),
    .vwe3           (vwe3),
    .vwa3           (vwa3),
    .vwd3           (vwd3),
    .bad_addr_err   (bad_addr_err),
    .err_req_id     (err_req_id),
    .conflict_count (conflict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_e;

  int  gq[$];
  wr_e wq[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  logic [N-1:0] pend = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setr(input int i, input logic v, input logic [AW-1:0] a, input logic [7:0] b);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = {32{b}};
  endtask

  // Expected transfer from requester g; wr says whether it reaches the regfile
  task automatic exp_x(input int g, input logic wr, input logic [AW-1:0] a, input logic [7:0] b);
    wr_e e;
    gq.push_back(g);
    if (wr) begin
      e.a = a;
      e.d = {32{b}};
      wq.push_back(e);
    end
  endtask

  // Monitor: compare every grant and every regfile write against the queues
  always @(negedge clk) begin
    if (|req_ready) begin
      n_tests++;
      if (gq.size() == 0) begin
        n_fail++;
        $display("FAIL grant_unexpected: got ready=%b expected none", req_ready);
      end else begin
        int g;
        logic [N-1:0] oh;
        g  = gq.pop_front();
        oh = N'(1 << g);
        if (req_ready !== oh) begin
          n_fail++;
          $display("FAIL grant_order: got ready=%b expected %b", req_ready, oh);
        end
      end
    end
    if (vwe3) begin
      n_tests++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got vwa3=%0d expected no write", vwa3);
      end else begin
        wr_e e;
        e = wq.pop_front();
        if (vwa3 !== e.a || vwd3 !== e.d) begin
          n_fail++;
          $display("FAIL write_data: got addr=%0d data=%h expected addr=%0d data=%h",
                   vwa3, vwd3[63:0], e.a, e.d[63:0]);
        end
      end
    end
  end

  // Handshake rule: a pending request may not be withdrawn before its grant
  always @(negedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          assert (req_valid[i]) else begin
            n_fail++;
            $display("FAIL valid_dropped: requester %0d got valid=0 expected 1", i);
          end
        end
      end
      pend <= req_valid & ~req_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wb_stall = 1'b0; cnt_clr = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    cyc(); cyc();

    // Reset state; ready forced low even with both requesters valid
    setr(0, 1'b1, 5'd16, 8'h01);
    setr(1, 1'b1, 5'd17, 8'h02);
    @(negedge clk);
    chk("rst_ready",  32'(req_ready), 32'h0);
    chk("rst_vwe3",   32'(vwe3), 32'h0);
    chk("rst_vwa3",   32'(vwa3), 32'h0);
    chk("rst_vwd3",   32'(|vwd3), 32'h0);
    chk("rst_err",    32'(bad_addr_err), 32'h0);
    chk("rst_err_id", 32'(err_req_id), 32'h0);
    chk("rst_cnt",    conflict_count, 32'h0);
    cyc();
    rst = 1'b0;
    req_valid = '0;

    // Single request from requester 0
    setr(0, 1'b1, 5'd17, 8'hA5);
    exp_x(0, 1'b1, 5'd17, 8'hA5);
    @(negedge clk);
    chk("t1_ready_same_cycle", 32'(req_ready), 32'h1);
    cyc();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_vwe3_next", 32'(vwe3), 32'h1);
    chk("t1_vwa3_next", 32'(vwa3), 32'd17);
    cyc();

    // Back-to-back transfers from requester 1 alone
    setr(1, 1'b1, 5'd19, 8'h77);
    exp_x(1, 1'b1, 5'd19, 8'h77);
    @(negedge clk);
    chk("t1_vwe3_after", 32'(vwe3), 32'h0);
    cyc();
    setr(1, 1'b1, 5'd21, 8'h78);
    exp_x(1, 1'b1, 5'd21, 8'h78);
    @(negedge clk);
    chk("b2b_ready", 32'(req_ready), 32'h2);
    chk("b2b_vwe3",  32'(vwe3), 32'h1);
    cyc();
    req_valid = '0;
    cyc();

    // Contention: grants 0,1,0,1 then the last pending req0 alone
    setr(0, 1'b1, 5'd16, 8'h11);
    setr(1, 1'b1, 5'd17, 8'h22);
    exp_x(0, 1'b1, 5'd16, 8'h11);
    cyc();
    setr(0, 1'b1, 5'd18, 8'h13);
    exp_x(1, 1'b1, 5'd17, 8'h22);
    @(negedge clk);
    chk("cont_vwe3_c2", 32'(vwe3), 32'h1);
    cyc();
    setr(1, 1'b1, 5'd19, 8'h24);
    exp_x(0, 1'b1, 5'd18, 8'h13);
    @(negedge clk);
    chk("cont_vwe3_c3", 32'(vwe3), 32'h1);
    cyc();
    setr(0, 1'b1, 5'd20, 8'h15);
    exp_x(1, 1'b1, 5'd19, 8'h24);
    @(negedge clk);
    chk("cont_vwe3_c4", 32'(vwe3), 32'h1);
    cyc();
    req_valid[1] = 1'b0;
    exp_x(0, 1'b1, 5'd20, 8'h15);
    @(negedge clk);
    chk("cont_vwe3_c5", 32'(vwe3), 32'h1);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("cont_count", conflict_count, 32'd4);
    chk("cont_vwe3_last", 32'(vwe3), 32'h1);
    cyc();

    // Clear the counter before the stall test
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_count", conflict_count, 32'h0);
    cyc();

    // Stall for 3 cycles with requester 1 pending
    wb_stall = 1'b1;
    setr(1, 1'b1, 5'd20, 8'h33);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready", 32'(req_ready), 32'h0);
      chk("stall_vwe3",  32'(vwe3), 32'h0);
      cyc();
    end
    wb_stall = 1'b0;
    exp_x(1, 1'b1, 5'd20, 8'h33);
    @(negedge clk);
    chk("stall_release_ready", 32'(req_ready), 32'h2);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("stall_count", conflict_count, 32'd3);
    chk("stall_vwe3_after", 32'(vwe3), 32'h1);
    cyc();
    @(negedge clk);
    chk("idle_vwe3", 32'(vwe3), 32'h0);
    chk("idle_vwa3_hold", 32'(vwa3), 32'd20);
    cyc();

    // Out-of-range writes: perf address from req1, then addr 5 from req0
    setr(1, 1'b1, 5'd25, 8'h44);
    exp_x(1, 1'b0, 5'd25, 8'h44);
    @(negedge clk);
    chk("bad1_ready", 32'(req_ready), 32'h2);
    cyc();
    req_valid[1] = 1'b0;
    setr(0, 1'b1, 5'd5, 8'h45);
    exp_x(0, 1'b0, 5'd5, 8'h45);
    @(negedge clk);
    chk("bad1_vwe3",   32'(vwe3), 32'h0);
    chk("bad1_err",    32'(bad_addr_err), 32'h1);
    chk("bad1_err_id", 32'(err_req_id), 32'h1);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("bad2_vwe3",   32'(vwe3), 32'h0);
    chk("bad2_err",    32'(bad_addr_err), 32'h1);
    chk("bad2_err_id", 32'(err_req_id), 32'h1);
    cyc();

    // Reset mid-operation: transfer in t, reset in t+1
    setr(0, 1'b1, 5'd18, 8'h55);
    exp_x(0, 1'b1, 5'd18, 8'h55);
    cyc();
    req_valid = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_vwe3", 32'(vwe3), 32'h0);
    chk("mrst_cnt",  conflict_count, 32'h0);
    chk("mrst_err",  32'(bad_addr_err), 32'h0);
    cyc();
    setr(0, 1'b1, 5'd22, 8'h56);
    setr(1, 1'b1, 5'd23, 8'h57);
    exp_x(0, 1'b1, 5'd22, 8'h56);
    @(negedge clk);
    chk("mrst_first_grant", 32'(req_ready), 32'h1);
    cyc();
    req_valid[0] = 1'b0;
    exp_x(1, 1'b1, 5'd23, 8'h57);
    cyc();
    req_valid = '0;
    cyc();

    // Counter saturation and clear while conflicting
    wb_stall = 1'b1;
    setr(0, 1'b1, 5'd16, 8'h66);
    force dut.conflict_q = 32'hFFFF_FFFE;
    release dut.conflict_q;
    cyc();
    @(negedge clk);
    chk("sat_reach", conflict_count, 32'hFFFF_FFFF);
    cyc();
    @(negedge clk);
    chk("sat_hold", conflict_count, 32'hFFFF_FFFF);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("sat_clr", conflict_count, 32'h0);
    cyc();
    @(negedge clk);
    chk("sat_inc_after_clr", conflict_count, 32'h1);
    wb_stall = 1'b0;
    exp_x(0, 1'b1, 5'd16, 8'h66);
    cyc();
    req_valid = '0;
    cyc(); cyc(); cyc();

    chk("grant_queue_drained", 32'(gq.size()), 32'h0);
    chk("write_queue_drained", 32'(wq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vrf_wb_arbiter.md
Name: vrf_wb_arbiter

Overview:
Shares the single write port (vwe3/vwa3/vwd3) of the vector register file between N_REQ writeback requesters, such as the vector ALU and the vector load unit. It uses valid/ready handshakes with round-robin fairness and registers the chosen write for one cycle. It also rejects writes outside the writable vector bank, and counts arbitration conflicts for performance monitoring.

Parameters:
N_REQ, 2, number of writeback requesters (2..8)
DATA_W, 256, vector register width
ADDR_W, 5, register address width
VREG_LO, 16, lowest writable vector register index
VREG_HI, 23, highest writable vector register index

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  N_REQ  per-requester write request
req_addr  in  N_REQ*ADDR_W  packed destination addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  N_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  one-hot grant; transfer when valid&ready
wb_stall  in  1  pipeline freeze; no grants while high
cnt_clr  in  1  clears conflict_count
vwe3  out  1  regfile write enable (registered)
vwa3  out  ADDR_W  regfile write address (registered)
vwd3  out  DATA_W  regfile write data (registered)
bad_addr_err  out  1  sticky: an out-of-range write was accepted
err_req_id  out  3  requester index of the first out-of-range write
conflict_count  out  32  cycles in which a valid requester was denied

Behaviour:
- Reset (rst=1 at posedge):
  - vwe3, vwa3, vwd3 = 0; rr_ptr = 0; bad_addr_err = 0; err_req_id = 0; conflict_count = 0.
  - req_ready is forced to 0 while rst=1.
  - A transfer in flight is discarded, with no write issued.
- Grant is combinational from req_valid, rr_ptr, wb_stall and rst:
  - Search i = rr_ptr, rr_ptr+1, … mod N_REQ; the first valid requester receives req_ready=1.
  - At most one req_ready is high; all are low if wb_stall=1 or no requester is valid.
  - req_ready never depends on req_addr or req_data.
- Handshake rules:
  - A requester holds valid, addr and data stable until it sees ready.
  - Deasserting valid without a handshake is illegal (assertion in the bench).
- Pointer: on a transfer from requester g, rr_ptr <= (g+1) mod N_REQ; otherwise rr_ptr holds.
- Latency: a transfer in cycle t drives vwe3/vwa3/vwd3 during cycle t+1, and the regfile commits on that cycle's falling edge.
  - Throughput is one write per cycle.
- Cycles with no transfer (idle or stalled) load vwe3=0; vwa3 and vwd3 hold their previous values.
- Range check (VREG_LO <= addr <= VREG_HI):
  - Out-of-range transfers still complete the handshake (the requester is not blocked) but produce vwe3=0.
  - Such a transfer sets bad_addr_err.
  - err_req_id captures g only when bad_addr_err was previously 0.
  - Perf addresses 24..27 are out of range (read-only).
- conflict_count:
  - Increments by 1 each cycle where wb_stall=0 and at least two requesters are valid.
  - Also increments each cycle where wb_stall=1 and at least one requester is valid.
  - Saturates at 0xFFFF_FFFF.
  - cnt_clr=1 loads 0, taking priority over increment; rst has priority over everything.
- Simultaneous events:
  - A requester whose valid rises in the same cycle as a grant to another requester waits; no preemption.
  - A back-to-back transfer from the same requester is allowed when it is the only one valid.

Decomposition:
- Package vrf_pkg holds:
  - DATA_W, ADDR_W, VREG_LO, VREG_HI.
  - Perf register address constants PERF_STALL=24, PERF_CPI=25, PERF_ARITH=26, PERF_MEM=27.
  - A vrf_wr_t struct (we, addr, data).
- Sub-module rr_arbiter (parameter N) holds the combinational rotate-priority grant and the rr_ptr register, with inputs req, en and rst.
  - vrf_wb_arbiter adds the output register, the range check, the error capture and the counter.

Test Plan:
- Reset then single request:
  - Stimulus: req0 valid, addr=17, data=0xA5.. (repeated).
  - Required response: ready0 in the same cycle; next cycle vwe3=1, vwa3=17, vwd3=0xA5..; the following cycle vwe3=0.
- Contention with N_REQ=2:
  - Stimulus: both valid for 4 cycles, each re-presenting a new request after every handshake.
  - Required response: grants alternate 0,1,0,1; conflict_count=4; vwe3 high for 4 consecutive cycles.
- Stall:
  - Stimulus: wb_stall=1 for 3 cycles with req1 valid, addr=20.
  - Required response: ready1 stays 0 and vwe3 stays 0; conflict_count=3; grant in the first cycle after the stall drops.
- Bad address:
  - Stimulus: req1 writes addr=25, then req0 writes addr=5.
  - Required response: both handshake and vwe3 stays 0; bad_addr_err=1 and err_req_id=1, not overwritten by the second error.
- Reset mid-operation:
  - Stimulus: transfer addr=18 in cycle t; rst=1 in cycle t+1.
  - Required response: after that edge, vwe3=0 and conflict_count=0; rr_ptr=0, so a later dual request grants requester 0 first.
- Counter edge cases:
  - Stimulus: preload near saturation via a long contention run (or force) to 0xFFFF_FFFF, keep conflicting, then pulse cnt_clr while conflicting.
  - Required response: count holds at 0xFFFF_FFFF; after the cnt_clr edge it reads 0, then increments to 1.
